coef_bank_seq: RTL

- Parametrised, runtime-loadable successor to the fixed per-state constant table.
- Holds NUM_BANKS banks of NUM_COEF signed coefficients, each CANT_BITS wide, in the servo Q8.8 format.
- Double-buffered: the controller rewrites the shadow bank while the active bank is streamed, one coefficient per cycle, into the control-law MAC datapath.
- Bank swaps occur only at sweep boundaries, so no sweep ever mixes coefficients from two banks.

---
 rtl/coef_bank_seq.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/coef_bank_seq.sv
// coef_bank_seq: double-buffered Q8.8 coefficient bank, streamed one value per cycle into the MAC.
// Writes always land in the shadow bank; bank swaps are taken only while the sequencer is idle.
module coef_bank_seq #(
    parameter int CANT_BITS = 16,
    parameter int NUM_COEF  = 8,
    parameter int ADDR_BITS = 3,
    parameter int NUM_BANKS = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        swap_req,
    input  logic                        wr_en,
    input  logic        [ADDR_BITS-1:0] wr_addr,
    input  logic signed [CANT_BITS-1:0] wr_data,
    output logic                        wr_ack,
    output logic                        wr_err,
    output logic signed [CANT_BITS-1:0] coef_out,
    output logic        [ADDR_BITS-1:0] coef_idx,
    output logic                        coef_valid,
    output logic                        coef_last,
    output logic                        done,
    output logic                        busy,
    output logic                        active_bank,
    output logic                        swap_pend
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_BITS-1:0] LAST_IDX  = ADDR_BITS'(NUM_COEF - 1);
    localparam bit                   HAS_HOLES = ((2 ** ADDR_BITS) > NUM_COEF);

    logic signed [CANT_BITS-1:0] mem_q [NUM_BANKS][NUM_COEF];

    state_t                      state_q, state_d;
    logic        [ADDR_BITS-1:0] idx_q, idx_d;
    logic signed [CANT_BITS-1:0] coef_q, coef_d;
    logic                        valid_q, valid_d;
    logic                        last_q, last_d;
    logic                        done_q, done_d;
    logic                        busy_q, busy_d;
    logic                        ack_q, ack_d;
    logic                        err_q, err_d;
    logic                        active_q, active_d;
    logic                        pend_q, pend_d;

    logic                        swap_apply_s;
    logic                        wr_in_range_s;
    logic                        wr_commit_s;
    logic                        wr_bank_s;
    logic                        rd_bank_s;
    logic        [ADDR_BITS-1:0] rd_idx_s;
    logic signed [CANT_BITS-1:0] rd_val_s;

    // Index range check is only needed when the address space has unused codes
    generate
        if (HAS_HOLES) begin : g_range_chk
            assign wr_in_range_s = ({1'b0, wr_addr} < (ADDR_BITS + 1)'(NUM_COEF));
        end else begin : g_range_full
            assign wr_in_range_s = 1'b1;
        end
    endgenerate

    // Swap bookkeeping and write acceptance
    always_comb begin
        swap_apply_s = (state_q == ST_IDLE) && (pend_q || swap_req);
        if (swap_apply_s) begin
            active_d = ~active_q;
            pend_d   = 1'b0;
        end else begin
            active_d = active_q;
            pend_d   = pend_q | swap_req;
        end
        wr_bank_s   = ~active_q;
        wr_commit_s = wr_en & wr_in_range_s;
        ack_d       = wr_commit_s;
        err_d       = wr_en & ~wr_in_range_s;
    end

    // Read port for the next streamed value; a same-edge write is forwarded so a
    // write coinciding with a swap-and-start is already visible at index 0.
    always_comb begin
        if (state_q == ST_IDLE) begin
            rd_bank_s = active_d;
            rd_idx_s  = '0;
        end else begin
            rd_bank_s = active_q;
            rd_idx_s  = idx_q + ADDR_BITS'(1);
        end
        if (wr_commit_s && (wr_bank_s == rd_bank_s) && (wr_addr == rd_idx_s)) begin
            rd_val_s = wr_data;
        end else begin
            rd_val_s = mem_q[rd_bank_s][rd_idx_s];
        end
    end

    // Sweep sequencer next state and registered stream outputs
    always_comb begin
        state_d = state_q;
        idx_d   = '0;
        coef_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    coef_d  = rd_val_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    idx_d   = rd_idx_s;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    last_d  = (rd_idx_s == LAST_IDX);
                    coef_d  = rd_val_s;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            coef_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            coef_q   <= coef_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            active_q <= active_d;
            pend_q   <= pend_d;
        end
    end

    // Coefficient storage, written only through the shadow bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < NUM_COEF; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else if (wr_commit_s) begin
            mem_q[wr_bank_s][wr_addr] <= wr_data;
        end
    end

    assign coef_out    = coef_q;
    assign coef_idx    = idx_q;
    assign coef_valid  = valid_q;
    assign coef_last   = last_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign wr_ack      = ack_q;
    assign wr_err      = err_q;
    assign active_bank = active_q;
    assign swap_pend   = pend_q;

endmodule
